pi_txn_frontend: RTL and testbench
==================================

# pi_txn_frontend

Pi-side transaction front end of the PiStorm CPLD. Synchronises the Raspberry Pi register-bus strobes into the 200 MHz `PI_CLK` domain, decodes register writes into a 68000 bus-cycle descriptor, and hands that descriptor to the 68K bus engine over a req/ack/done handshake. It also owns the status register, the sticky error flags, and the status read-back word. An optional watchdog aborts transactions that hang.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 65535: `PI_CLK` cycles allowed in BUSY before abort (only with `PI_TXN_TIMEOUT_EN`); valid range 2..65535.

Ports:
- `PI_CLK`  in  1  200 MHz clock; sole clock of the block.
- `RST`  in  1  synchronous, active-high reset.
- `PI_A`  in  2  register select: 0 DATA, 1 ADDR_LO, 2 ADDR_HI, 3 STATUS.
- `PI_RD`, `PI_WR`  in  1  asynchronous Pi strobes.
- `PI_D_IN`  in  16  Pi data bus, input side.
- `PI_D_OUT`  out  16  status read-back word.
- `PI_D_OE`  out  1  combinational; `PI_A==3 && PI_RD`.
- `PI_TXN_IN_PROGRESS`  out  1  busy flag to the Pi.
- `STATUS`  out  16  last value written to REG_STATUS; bit1 = 1 releases 68K reset.
- `TXN_REQ`  out  1  descriptor valid.
- `TXN_RW`, `TXN_UDS_N`, `TXN_LDS_N`  out  1  descriptor fields.
- `TXN_FC`  out  3  function code.
- `TXN_ACK`  in  1  one-cycle pulse; engine has accepted the descriptor.
- `TXN_DONE`  in  1  one-cycle pulse; bus cycle completed (S7).
- `TXN_ABORT`  out  1  one-cycle pulse on watchdog abort.
- `BERR_EVT`  in  1  bus-error pulse from the engine.
- `IPL`  in  3  filtered interrupt level from the engine.
- `BUS_RESET`  in  1  68K RESET and HALT asserted externally.

## Operation
- Each strobe passes through a 2-flop synchroniser plus a rising-edge detect. `PI_A` and `PI_D_IN` are sampled at the detect edge; the Pi holds them stable for the whole strobe.
- ADDR_LO write: a0 <= `PI_D_IN[0]`, `PI_TXN_IN_PROGRESS` <= 1, state -> ARMED.
- ADDR_HI write, in IDLE or ARMED:
  - rw = D[9], fc = D[15:13].
  - If byte access (D[8]=1): uds_n = a0, lds_n = !a0.
  - If word access: uds_n = lds_n = 0.
  - `TXN_REQ` <= 1, `PI_TXN_IN_PROGRESS` <= 1, state -> REQ.
- ADDR_LO or ADDR_HI write in REQ or BUSY: ignored; sets sticky proto_err.
- STATUS write: `STATUS` <= `PI_D_IN`, accepted in any state.
- DATA writes and reads: no effect; the external latches handle them.
- States and transitions:
  - IDLE -> ARMED on ADDR_LO write.
  - IDLE or ARMED -> REQ on ADDR_HI write.
  - REQ -> BUSY on `TXN_ACK`; `TXN_REQ` drops on the same edge. Descriptor fields stay stable until DONE or abort.
  - BUSY -> IDLE on `TXN_DONE`; `PI_TXN_IN_PROGRESS` <= 0.
- Read-back word: `PI_D_OUT` = {IPL[2:0], 10'd0, timeout, proto_err, berr_seen}. It is registered on a STATUS read edge, and the sticky bits clear on that same edge.
- If `BERR_EVT` (or a set condition) coincides with the clearing read: the set wins, and the next read shows 1.
- `BUSY_RESET` priority: when `BUS_RESET` is high and `STATUS[1]==1`, force IDLE, `TXN_REQ`=0 and `PI_TXN_IN_PROGRESS`=0 every cycle. `STATUS` and the sticky bits are kept.
- Reset values: state IDLE; `TXN_REQ`=0, `PI_TXN_IN_PROGRESS`=0, `TXN_ABORT`=0; `TXN_RW`=1, `TXN_UDS_N`=1, `TXN_LDS_N`=1, `TXN_FC`=3'b111; `STATUS`=0 (68K held in reset); `PI_D_OUT`=0; sticky bits 0; a0=0.

## Timing
- Strobe rising at the Pi pins: the first `PI_CLK` edge samples it, and the resulting action is registered on the 2nd edge. The latency is therefore 2 cycles, plus up to 1 cycle of sampling uncertainty.
- A strobe high time of at least 3 `PI_CLK` cycles is required. Back-to-back strobes need at least 2 low cycles between them.
- ADDR_HI write to `TXN_REQ` high: 2 edges.
- `TXN_ACK` -> `TXN_REQ` low: next edge.
- `TXN_DONE` -> `PI_TXN_IN_PROGRESS` low: next edge.
- `TXN_ACK` and `TXN_DONE` arriving in the same cycle while in REQ: treat as ack followed by done, going straight to IDLE.
- `TXN_DONE` outside BUSY, or `TXN_ACK` outside REQ: ignored.
- `RST` overrides everything, including `BUS_RESET`.

## Configuration
- `PI_TXN_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to BUSY and increments every BUSY cycle.
  - When the count reaches `TIMEOUT_CYCLES-1` without `TXN_DONE`: pulse `TXN_ABORT` for 1 cycle, set sticky timeout, go to IDLE, and drive `PI_TXN_IN_PROGRESS` to 0.
  - If `TXN_DONE` arrives on that same cycle, done wins and no abort occurs.
- Undefined: no counter; `TXN_ABORT` is tied to 0, the timeout bit reads 0, and BUSY waits indefinitely.

## Test plan
- Reset, then read STATUS -> `PI_D_OUT`=0x0000, `TXN_REQ`=0, `STATUS`=0.
- Write ADDR_LO D=0x0001, then ADDR_HI D=0xA300 (fc=5, rw=1, byte) -> `TXN_REQ`=1, `TXN_FC`=5, `TXN_RW`=1, `TXN_UDS_N`=1, `TXN_LDS_N`=0. Then `TXN_ACK` -> REQ drops next edge; `TXN_DONE` -> `PI_TXN_IN_PROGRESS`=0.
- Word write: ADDR_LO D=0x0000, ADDR_HI D=0x2000 -> UDS_N=0, LDS_N=0, RW=0, FC=1. A second ADDR_HI write while in BUSY is ignored -> next STATUS read shows bit1=1, and the read after that shows 0.
- `BERR_EVT` pulse, then read STATUS with `IPL`=3 -> `PI_D_OUT`=0x6001. Assert `BERR_EVT` on the clearing edge -> the next read still shows bit0=1.
- Write STATUS=0x0002, then assert `BUS_RESET` during BUSY -> IDLE, REQ=0, `PI_TXN_IN_PROGRESS`=0, `STATUS` still 0x0002.
- With `PI_TXN_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: ACK and no DONE -> `TXN_ABORT` pulses 16 cycles after BUSY entry, and STATUS read bit2=1.

Source files
------------

// File: rtl/pi_txn_frontend.sv
// Pi-side transaction front end: strobe sync, register decode, 68K descriptor handshake, status/sticky flags.
// Optional watchdog abort enabled by defining PI_TXN_TIMEOUT_EN.
module pi_txn_frontend #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        PI_CLK,
    input  logic        RST,
    input  logic [1:0]  PI_A,
    input  logic        PI_RD,
    input  logic        PI_WR,
    input  logic [15:0] PI_D_IN,
    output logic [15:0] PI_D_OUT,
    output logic        PI_D_OE,
    output logic        PI_TXN_IN_PROGRESS,
    output logic [15:0] STATUS,
    output logic        TXN_REQ,
    output logic        TXN_RW,
    output logic        TXN_UDS_N,
    output logic        TXN_LDS_N,
    output logic [2:0]  TXN_FC,
    input  logic        TXN_ACK,
    input  logic        TXN_DONE,
    output logic        TXN_ABORT,
    input  logic        BERR_EVT,
    input  logic [2:0]  IPL,
    input  logic        BUS_RESET
);
    localparam int unsigned CNT_W = 16;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 2..65535");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_REQ, ST_BUSY} state_t;

    state_t state, state_d;
    logic   rd_s1, rd_s2, wr_s1, wr_s2;
    logic   a0, a0_d;
    logic   berr_q, proto_q, timeout_q;
    logic   req_d, prog_d, rw_d, uds_d, lds_d, abort_d, proto_set;
    logic [2:0] fc_d;
    logic   rd_status_c, wr_lo_c, wr_hi_c, wr_status_c, bus_hold_c, wd_expire_c;

    // Rising-edge detect on the first synchroniser stage gives the 2-edge strobe latency
    assign rd_status_c = rd_s1 && !rd_s2 && (PI_A == 2'd3);
    assign wr_lo_c     = wr_s1 && !wr_s2 && (PI_A == 2'd1);
    assign wr_hi_c     = wr_s1 && !wr_s2 && (PI_A == 2'd2);
    assign wr_status_c = wr_s1 && !wr_s2 && (PI_A == 2'd3);
    assign bus_hold_c  = BUS_RESET && STATUS[1];
    assign PI_D_OE     = (PI_A == 2'd3) && PI_RD;

`ifdef PI_TXN_TIMEOUT_EN
    logic [CNT_W-1:0] wd_cnt;

    // Held at zero outside BUSY, so it starts from zero on every BUSY entry
    always_ff @(posedge PI_CLK) begin
        if (RST || state != ST_BUSY) wd_cnt <= '0;
        else                         wd_cnt <= wd_cnt + CNT_W'(1);
    end

    assign wd_expire_c = (state == ST_BUSY) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expire_c = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        req_d     = TXN_REQ;
        prog_d    = PI_TXN_IN_PROGRESS;
        rw_d      = TXN_RW;
        uds_d     = TXN_UDS_N;
        lds_d     = TXN_LDS_N;
        fc_d      = TXN_FC;
        a0_d      = a0;
        abort_d   = 1'b0;
        proto_set = 1'b0;
        case (state)
            ST_IDLE, ST_ARMED: begin
                if (wr_lo_c) begin
                    a0_d    = PI_D_IN[0];
                    prog_d  = 1'b1;
                    state_d = ST_ARMED;
                end else if (wr_hi_c) begin
                    rw_d    = PI_D_IN[9];
                    fc_d    = PI_D_IN[15:13];
                    uds_d   = PI_D_IN[8] ? a0 : 1'b0;
                    lds_d   = PI_D_IN[8] ? !a0 : 1'b0;
                    req_d   = 1'b1;
                    prog_d  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                proto_set = wr_lo_c || wr_hi_c;
                if (TXN_ACK) begin
                    req_d = 1'b0;
                    if (TXN_DONE) begin
                        state_d = ST_IDLE;
                        prog_d  = 1'b0;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                proto_set = wr_lo_c || wr_hi_c;
                if (TXN_DONE || wd_expire_c) begin
                    abort_d = !TXN_DONE;
                    state_d = ST_IDLE;
                    prog_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // External 68K reset with the CPU released forces the front end idle
        if (bus_hold_c) begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            prog_d  = 1'b0;
            abort_d = 1'b0;
        end
    end

    always_ff @(posedge PI_CLK) begin
        if (RST) begin
            state              <= ST_IDLE;
            rd_s1              <= 1'b0;
            rd_s2              <= 1'b0;
            wr_s1              <= 1'b0;
            wr_s2              <= 1'b0;
            a0                 <= 1'b0;
            TXN_REQ            <= 1'b0;
            PI_TXN_IN_PROGRESS <= 1'b0;
            TXN_ABORT          <= 1'b0;
            TXN_RW             <= 1'b1;
            TXN_UDS_N          <= 1'b1;
            TXN_LDS_N          <= 1'b1;
            TXN_FC             <= 3'b111;
            STATUS             <= '0;
            PI_D_OUT           <= '0;
            berr_q             <= 1'b0;
            proto_q            <= 1'b0;
            timeout_q          <= 1'b0;
        end else begin
            state              <= state_d;
            rd_s1              <= PI_RD;
            rd_s2              <= rd_s1;
            wr_s1              <= PI_WR;
            wr_s2              <= wr_s1;
            a0                 <= a0_d;
            TXN_REQ            <= req_d;
            PI_TXN_IN_PROGRESS <= prog_d;
            TXN_ABORT          <= abort_d;
            TXN_RW             <= rw_d;
            TXN_UDS_N          <= uds_d;
            TXN_LDS_N          <= lds_d;
            TXN_FC             <= fc_d;
            if (wr_status_c) STATUS <= PI_D_IN;
            if (rd_status_c) PI_D_OUT <= {IPL, 10'd0, timeout_q, proto_q, berr_q};
            // A set coinciding with the clearing read wins
            berr_q    <= (berr_q    && !rd_status_c) || BERR_EVT;
            proto_q   <= (proto_q   && !rd_status_c) || proto_set;
            timeout_q <= (timeout_q && !rd_status_c) || abort_d;
        end
    end
endmodule

// File: tb/tb_pi_txn_frontend.sv
// Self-checking bench for pi_txn_frontend: descriptor vector table, scoreboarded status reads,
// and hand sequences for latency, protocol error, sticky race, bus reset and watchdog.
module tb_pi_txn_frontend;
    logic        PI_CLK = 1'b0;
    logic        RST;
    logic [1:0]  PI_A;
    logic        PI_RD, PI_WR;
    logic [15:0] PI_D_IN;
    logic [15:0] PI_D_OUT;
    logic        PI_D_OE, PI_TXN_IN_PROGRESS;
    logic [15:0] STATUS;
    logic        TXN_REQ, TXN_RW, TXN_UDS_N, TXN_LDS_N;
    logic [2:0]  TXN_FC;
    logic        TXN_ACK, TXN_DONE, TXN_ABORT, BERR_EVT, BUS_RESET;
    logic [2:0]  IPL;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    pi_txn_frontend #(.TIMEOUT_CYCLES(16)) dut (
        .PI_CLK(PI_CLK), .RST(RST), .PI_A(PI_A), .PI_RD(PI_RD), .PI_WR(PI_WR),
        .PI_D_IN(PI_D_IN), .PI_D_OUT(PI_D_OUT), .PI_D_OE(PI_D_OE),
        .PI_TXN_IN_PROGRESS(PI_TXN_IN_PROGRESS), .STATUS(STATUS), .TXN_REQ(TXN_REQ),
        .TXN_RW(TXN_RW), .TXN_UDS_N(TXN_UDS_N), .TXN_LDS_N(TXN_LDS_N), .TXN_FC(TXN_FC),
        .TXN_ACK(TXN_ACK), .TXN_DONE(TXN_DONE), .TXN_ABORT(TXN_ABORT),
        .BERR_EVT(BERR_EVT), .IPL(IPL), .BUS_RESET(BUS_RESET)
    );

    always #5 PI_CLK = ~PI_CLK;

    typedef struct {
        logic [15:0] lo_d;
        logic [15:0] hi_d;
        logic        rw;
        logic        uds_n;
        logic        lds_n;
        logic [2:0]  fc;
        logic        ack_done_same;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // Called on a negedge; 3 cycles high, 2 cycles low
    task automatic pi_write(input logic [1:0] a, input logic [15:0] d);
        PI_A = a; PI_D_IN = d; PI_WR = 1'b1;
        repeat (3) @(negedge PI_CLK);
        PI_WR = 1'b0;
        repeat (2) @(negedge PI_CLK);
    endtask

    task automatic read_status(input logic [15:0] exp, input logic berr_at_clear);
        logic [15:0] want;
        exp_q.push_back(exp);
        PI_A = 2'd3; PI_RD = 1'b1;
        @(negedge PI_CLK);
        check("pi_d_oe", 16'(PI_D_OE), 16'd1);
        if (berr_at_clear) BERR_EVT = 1'b1;
        @(negedge PI_CLK);
        BERR_EVT = 1'b0;
        @(negedge PI_CLK);
        PI_RD = 1'b0;
        repeat (2) @(negedge PI_CLK);
        want = exp_q.pop_front();
        check("status_read", PI_D_OUT, want);
    endtask

    task automatic pulse(input logic ack, input logic done);
        TXN_ACK = ack; TXN_DONE = done;
        @(negedge PI_CLK);
        TXN_ACK = 1'b0; TXN_DONE = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int cyc;
        vecs[0] = '{16'h0001, 16'hA300, 1'b1, 1'b1, 1'b0, 3'd5, 1'b0};
        vecs[1] = '{16'h0000, 16'h2000, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
        vecs[2] = '{16'h0000, 16'h4100, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1};
        vecs[3] = '{16'hFFFF, 16'hE200, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0};
        vecs[4] = '{16'h0003, 16'h0100, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1};

        RST = 1'b1; PI_A = '0; PI_RD = 1'b0; PI_WR = 1'b0; PI_D_IN = '0;
        TXN_ACK = 1'b0; TXN_DONE = 1'b0; BERR_EVT = 1'b0; IPL = '0; BUS_RESET = 1'b0;
        repeat (4) @(negedge PI_CLK);
        RST = 1'b0;
        @(negedge PI_CLK);

        check("rst_pi_d_out", PI_D_OUT, 16'h0000);
        check("rst_txn_req", 16'(TXN_REQ), 16'd0);
        check("rst_status", STATUS, 16'h0000);
        check("rst_in_progress", 16'(PI_TXN_IN_PROGRESS), 16'd0);
        check("rst_fields", {12'd0, TXN_RW, TXN_UDS_N, TXN_LDS_N, 1'b0}, 16'h000E);
        check("rst_fc", 16'(TXN_FC), 16'd7);
        check("rst_abort", 16'(TXN_ABORT), 16'd0);
        check("rst_pi_d_oe", 16'(PI_D_OE), 16'd0);
        read_status(16'h0000, 1'b0);

        // ACK outside REQ is ignored
        pulse(1'b1, 1'b0);
        check("idle_ack_req", 16'(TXN_REQ), 16'd0);
        check("idle_ack_prog", 16'(PI_TXN_IN_PROGRESS), 16'd0);

        for (int i = 0; i < 5; i++) begin
            pi_write(2'd1, vecs[i].lo_d);
            pi_write(2'd2, vecs[i].hi_d);
            check($sformatf("v%0d_req", i), 16'(TXN_REQ), 16'd1);
            check($sformatf("v%0d_prog", i), 16'(PI_TXN_IN_PROGRESS), 16'd1);
            check($sformatf("v%0d_rw", i), 16'(TXN_RW), 16'(vecs[i].rw));
            check($sformatf("v%0d_uds_n", i), 16'(TXN_UDS_N), 16'(vecs[i].uds_n));
            check($sformatf("v%0d_lds_n", i), 16'(TXN_LDS_N), 16'(vecs[i].lds_n));
            check($sformatf("v%0d_fc", i), 16'(TXN_FC), 16'(vecs[i].fc));
            if (vecs[i].ack_done_same) begin
                pulse(1'b1, 1'b1);
                check($sformatf("v%0d_same_req", i), 16'(TXN_REQ), 16'd0);
                check($sformatf("v%0d_same_prog", i), 16'(PI_TXN_IN_PROGRESS), 16'd0);
            end else begin
                pulse(1'b1, 1'b0);
                check($sformatf("v%0d_ack_req", i), 16'(TXN_REQ), 16'd0);
                check($sformatf("v%0d_busy_prog", i), 16'(PI_TXN_IN_PROGRESS), 16'd1);
                check($sformatf("v%0d_busy_fc", i), 16'(TXN_FC), 16'(vecs[i].fc));
                pulse(1'b0, 1'b1);
                check($sformatf("v%0d_done_prog", i), 16'(PI_TXN_IN_PROGRESS), 16'd0);
            end
        end

        // ADDR_HI -> TXN_REQ takes exactly two edges; DONE in ARMED is ignored
        pi_write(2'd1, 16'h0001);
        check("armed_prog", 16'(PI_TXN_IN_PROGRESS), 16'd1);
        pulse(1'b0, 1'b1);
        check("armed_done_ignored", 16'(PI_TXN_IN_PROGRESS), 16'd1);
        PI_A = 2'd2; PI_D_IN = 16'h2000; PI_WR = 1'b1;
        @(negedge PI_CLK);
        check("req_lat_edge1", 16'(TXN_REQ), 16'd0);
        @(negedge PI_CLK);
        check("req_lat_edge2", 16'(TXN_REQ), 16'd1);
        @(negedge PI_CLK);
        PI_WR = 1'b0;
        repeat (2) @(negedge PI_CLK);
        pulse(1'b1, 1'b0);

        // Second ADDR_HI in BUSY: ignored, proto_err sticky then cleared by read
        pi_write(2'd2, 16'hE300);
        check("proto_fc_kept", 16'(TXN_FC), 16'd1);
        check("proto_rw_kept", 16'(TXN_RW), 16'd0);
        check("proto_busy_prog", 16'(PI_TXN_IN_PROGRESS), 16'd1);
        check("proto_busy_req", 16'(TXN_REQ), 16'd0);
        pulse(1'b0, 1'b1);
        read_status(16'h0002, 1'b0);
        read_status(16'h0000, 1'b0);

        // BERR sticky with IPL, and a set colliding with the clearing read
        pulse(1'b0, 1'b0);
        BERR_EVT = 1'b1;
        @(negedge PI_CLK);
        BERR_EVT = 1'b0;
        IPL = 3'd3;
        read_status(16'h6001, 1'b1);
        read_status(16'h6001, 1'b0);
        read_status(16'h6000, 1'b0);
        IPL = 3'd0;

        pi_write(2'd3, 16'hBEEF);
        check("status_write_any", STATUS, 16'hBEEF);

        // BUS_RESET with 68K released forces idle during BUSY
        pi_write(2'd3, 16'h0002);
        check("status_0002", STATUS, 16'h0002);
        pi_write(2'd1, 16'h0000);
        pi_write(2'd2, 16'h2000);
        pulse(1'b1, 1'b0);
        BUS_RESET = 1'b1;
        @(negedge PI_CLK);
        check("busrst_prog", 16'(PI_TXN_IN_PROGRESS), 16'd0);
        check("busrst_req", 16'(TXN_REQ), 16'd0);
        check("busrst_status_kept", STATUS, 16'h0002);
        pi_write(2'd2, 16'h2000);
        check("busrst_hi_blocked", 16'(TXN_REQ), 16'd0);
        check("busrst_hi_prog", 16'(PI_TXN_IN_PROGRESS), 16'd0);
        BUS_RESET = 1'b0;
        @(negedge PI_CLK);
        pulse(1'b0, 1'b1);

        // BUS_RESET while 68K held in reset has no effect
        pi_write(2'd3, 16'h0000);
        pi_write(2'd2, 16'h2000);
        BUS_RESET = 1'b1;
        repeat (2) @(negedge PI_CLK);
        check("busrst_held_req", 16'(TXN_REQ), 16'd1);
        BUS_RESET = 1'b0;
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        check("busrst_held_done", 16'(PI_TXN_IN_PROGRESS), 16'd0);
        read_status(16'h0000, 1'b0);

`ifdef PI_TXN_TIMEOUT_EN
        // Watchdog: abort 16 edges after the BUSY entry edge
        pi_write(2'd2, 16'h2000);
        TXN_ACK = 1'b1;
        @(negedge PI_CLK);
        TXN_ACK = 1'b0;
        cyc = 1;
        while (!TXN_ABORT && cyc < 60) begin
            @(negedge PI_CLK);
            cyc++;
        end
        check("abort_latency", 16'(cyc - 1), 16'd16);
        check("abort_prog", 16'(PI_TXN_IN_PROGRESS), 16'd0);
        @(negedge PI_CLK);
        check("abort_one_cycle", 16'(TXN_ABORT), 16'd0);
        read_status(16'h0004, 1'b0);

        // DONE on the expiry cycle wins
        pi_write(2'd2, 16'h2000);
        TXN_ACK = 1'b1;
        @(negedge PI_CLK);
        TXN_ACK = 1'b0;
        repeat (15) @(negedge PI_CLK);
        TXN_DONE = 1'b1;
        @(negedge PI_CLK);
        TXN_DONE = 1'b0;
        check("done_wins_abort", 16'(TXN_ABORT), 16'd0);
        check("done_wins_prog", 16'(PI_TXN_IN_PROGRESS), 16'd0);
        @(negedge PI_CLK);
        check("done_wins_abort2", 16'(TXN_ABORT), 16'd0);
        read_status(16'h0000, 1'b0);
`else
        // Without the watchdog BUSY waits indefinitely
        pi_write(2'd2, 16'h2000);
        pulse(1'b1, 1'b0);
        cyc = 0;
        while (!TXN_ABORT && cyc < 80) begin
            @(negedge PI_CLK);
            cyc++;
        end
        check("no_abort", 16'(TXN_ABORT), 16'd0);
        check("no_abort_prog", 16'(PI_TXN_IN_PROGRESS), 16'd1);
        pulse(1'b0, 1'b1);
        read_status(16'h0000, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
